// File: rtl/axi_line_cache_pkg.sv
// Shared types and constants for the single-line AXI cache.
// Holds the FSM state encoding, the AXI field values and the beat-size helper.
package axi_line_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_RD   = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size code for one data word: log2 of the word width in bytes.
    function automatic logic [2:0] clog2_bytes(input int data_width);
        int bytes;
        logic [2:0] r;
        bytes = data_width / 8;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_line_cache_if.sv
// CPU request/response port plus the AXI4 master channels of the line cache.
// The slave modport is the cache's own view; master is the CPU + DRAM side.
interface axi_line_cache_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int CPU_AW     = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [CPU_AW-1:0]     req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  flush;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [6:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [6:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [ID_WIDTH-1:0]   awid;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush,
        input  arready, rdata, rresp, rlast, rvalid,
        input  awready, wready, bresp, bvalid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output araddr, arlen, arsize, arburst, arid, arvalid, rready,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        output wdata, wlast, wvalid, bready
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush,
        output arready, rdata, rresp, rlast, rvalid,
        output awready, wready, bresp, bvalid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        input  wdata, wlast, wvalid, bready
    );

endinterface

// File: rtl/axi_line_cache_line_buffer.sv
// Line storage: LINE_WORDS x DATA_WIDTH registers, one write port, one
// asynchronous read port. Contents are only trusted while the line is valid.
module axi_line_cache_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int LINE_WORDS = 16,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [OFF_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [OFF_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_line_cache.sv
// Single-line read cache with write-through between the CPU port and one AXI4
// master. Read misses fill the whole aligned line with one INCR burst.
module axi_line_cache
    import axi_line_cache_pkg::*;
#(
    parameter int                  DATA_WIDTH = 16,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  ID_WIDTH   = 4,
    parameter int                  CPU_AW     = 12,
    parameter int                  LINE_WORDS = 16,
    parameter logic [ADDR_WIDTH-1:0] DRAM_BASE = ADDR_WIDTH'(32'h1000)
) (
    input  logic   clk,
    input  logic   rst,
    axi_line_cache_if.slave bus,
    output state_t state_dbg
);

    localparam int         OFF_W = $clog2(LINE_WORDS);
    localparam int         TAG_W = CPU_AW - OFF_W;
    localparam logic [2:0] SIZE  = clog2_bytes(DATA_WIDTH);

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid && ready are both high; valid holds with stable payload until then.

    state_t                state, state_nx;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [CPU_AW-1:0]     lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [OFF_W-1:0]      beat_cnt;
    logic                  err_seen;
    logic                  flush_pend;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  accept, hit, rd_hs, last_hs, beat_err;
    logic [TAG_W-1:0]      req_tag;
    logic [OFF_W-1:0]      req_off, lat_off;
    logic                  buf_we;
    logic [OFF_W-1:0]      buf_waddr, buf_raddr;
    logic [DATA_WIDTH-1:0] buf_wdata, buf_rdata;

    function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [CPU_AW-1:0] w);
        return DRAM_BASE + (ADDR_WIDTH'(w) << SIZE);
    endfunction

    assign req_tag  = bus.req_addr[CPU_AW-1:OFF_W];
    assign req_off  = bus.req_addr[OFF_W-1:0];
    assign lat_off  = lat_addr[OFF_W-1:0];
    assign accept   = bus.req_valid && (state == S_IDLE);
    // A flush in the same cycle as a request takes effect first.
    assign hit      = line_valid && !bus.flush && (line_tag == req_tag);
    assign rd_hs    = (state == S_RD) && bus.rvalid;
    assign last_hs  = rd_hs && bus.rlast;
    assign beat_err = bus.rresp != AXI_RESP_OKAY;

    assign buf_we    = rd_hs || (accept && bus.req_we && hit);
    assign buf_waddr = rd_hs ? beat_cnt : req_off;
    assign buf_wdata = rd_hs ? bus.rdata : bus.req_wdata;
    assign buf_raddr = (state == S_IDLE) ? req_off : lat_off;

    axi_line_cache_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = bus.req_we ? S_AW : (hit ? S_IDLE : S_AR);
            S_AR:   if (bus.arready) state_nx = S_RD;
            S_RD:   if (last_hs)     state_nx = S_IDLE;
            S_AW:   if (bus.awready) state_nx = S_W;
            S_W:    if (bus.wready)  state_nx = S_B;
            S_B:    if (bus.bvalid)  state_nx = S_IDLE;
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == S_IDLE) && !rst;
        bus.busy      = (state != S_IDLE);
        bus.araddr    = byte_addr({lat_addr[CPU_AW-1:OFF_W], {OFF_W{1'b0}}});
        bus.arlen     = 7'(LINE_WORDS - 1);
        bus.arsize    = SIZE;
        bus.arburst   = AXI_BURST_INCR;
        bus.arid      = '0;
        bus.arvalid   = (state == S_AR);
        bus.rready    = (state == S_RD);
        bus.awaddr    = byte_addr(lat_addr);
        bus.awlen     = 7'd0;
        bus.awsize    = SIZE;
        bus.awburst   = AXI_BURST_INCR;
        bus.awid      = '0;
        bus.awvalid   = (state == S_AW);
        bus.wdata     = lat_wdata;
        bus.wvalid    = (state == S_W);
        bus.wlast     = (state == S_W);
        bus.bready    = (state == S_B);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid  <= 1'b0;
            line_tag    <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            beat_cnt    <= '0;
            err_seen    <= 1'b0;
            flush_pend  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.flush) line_valid <= 1'b0;
                if (accept) begin
                    lat_addr  <= bus.req_addr;
                    lat_wdata <= bus.req_wdata;
                    beat_cnt  <= '0;
                    err_seen  <= 1'b0;
                    if (!bus.req_we && hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= buf_rdata;
                        rsp_err_q   <= 1'b0;
                    end
                    if (!bus.req_we && !hit) line_valid <= 1'b0;
                end
            end else if (state_nx == S_IDLE) begin
                flush_pend <= 1'b0;
            end else if (bus.flush) begin
                flush_pend <= 1'b1;
            end
            if (rd_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_err) err_seen <= 1'b1;
            end
            // The final beat is still in flight to the buffer, so forward it.
            if (last_hs) begin
                line_tag    <= lat_addr[CPU_AW-1:OFF_W];
                line_valid  <= !(err_seen || beat_err) && !flush_pend && !bus.flush;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_seen || beat_err;
                rsp_rdata_q <= (beat_cnt == lat_off) ? bus.rdata : buf_rdata;
            end
            if ((state == S_B) && bus.bvalid) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_err_q   <= bus.bresp != AXI_RESP_OKAY;
                if (flush_pend || bus.flush) line_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_axi_line_cache.sv
// Directed bench for axi_line_cache: a vector table of CPU accesses checked
// against hand-computed results, a small AXI DRAM responder, and corner sequences.
module tb_axi_line_cache;
    import axi_line_cache_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int CAW = 12;
    localparam int LW  = 16;
    localparam int NV  = 14;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_line_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .CPU_AW(CAW)) bus ();

    axi_line_cache #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .CPU_AW     (CAW),
        .LINE_WORDS (LW),
        .DRAM_BASE  (32'h1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DRAM contents: word i starts as 16'hA000 + i; writes update it.
    logic [15:0] mem [0:4095];
    int          ar_count = 0;
    int          aw_count = 0;
    logic [31:0] cap_araddr, cap_awaddr;
    logic [6:0]  cap_arlen, cap_awlen;
    logic [2:0]  cap_arsize;
    logic [1:0]  cap_arburst;
    logic [15:0] cap_wdata;
    logic        cap_wlast;
    int          err_beat = -1;
    logic        b_err = 1'b0;
    int          rd_beat = -1;
    int          rlast_cyc = -1;

    // Read side of the DRAM model.
    initial begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.arvalid) begin
                logic [31:0] a0;
                int          base;
                a0 = bus.araddr;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("arvalid_hold", 32'(bus.arvalid), 32'd1);
                    chk("araddr_hold", bus.araddr, a0);
                end
                bus.arready = 1'b1;
                cap_araddr  = a0;
                cap_arlen   = bus.arlen;
                cap_arsize  = bus.arsize;
                cap_arburst = bus.arburst;
                ar_count++;
                @(negedge clk);
                bus.arready = 1'b0;
                base = int'((a0 - 32'h1000) >> 1);
                for (int k = 0; k < LW; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.rvalid = 1'b0;
                        @(negedge clk);
                        if (rst) break;
                    end
                    bus.rvalid = 1'b1;
                    bus.rdata  = mem[base + k];
                    bus.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
                    bus.rlast  = (k == LW - 1);
                    rd_beat    = k;
                    @(negedge clk);
                    if (rst) break;
                    if (k == LW - 1) rlast_cyc = cyc;
                end
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                bus.rresp  = 2'b00;
                rd_beat    = -1;
            end
        end
    end

    // Write side of the DRAM model.
    initial begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst && bus.awvalid) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.awready = 1'b1;
                cap_awaddr  = bus.awaddr;
                cap_awlen   = bus.awlen;
                aw_count++;
                @(negedge clk);
                bus.awready = 1'b0;
                chk("wvalid_after_aw", 32'(bus.wvalid), 32'd1);
                bus.wready = 1'b1;
                cap_wdata  = bus.wdata;
                cap_wlast  = bus.wlast;
                mem[(cap_awaddr - 32'h1000) >> 1] = bus.wdata;
                @(negedge clk);
                bus.wready = 1'b0;
                bus.bvalid = 1'b1;
                bus.bresp  = b_err ? 2'b10 : 2'b00;
                @(negedge clk);
                bus.bvalid = 1'b0;
                bus.bresp  = 2'b00;
            end
        end
    end

    task automatic send_req(input logic we, input logic [11:0] addr, input logic [15:0] wd,
                            input logic with_flush);
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.flush     = with_flush;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic wait_rsp(output logic [15:0] rd, output logic err, output int lat,
                            output int at_cyc);
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            rd = '0;
            err = 1'b0;
            at_cyc = -1;
        end else begin
            rd = bus.rsp_rdata;
            err = bus.rsp_err;
            at_cyc = cyc;
            @(negedge clk);
            chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        miss;
        logic [31:0] axaddr;
        logic [15:0] rdata;
    } vec_t;

    vec_t        vecs [NV];
    logic [15:0] rd;
    logic        err;
    int          lat, at, ar0, aw0;
    logic        found;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 + 16'(i);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.flush     = 1'b0;

        //          we    addr     wdata     miss  axaddr      rdata
        vecs[0]  = '{1'b0, 12'h005, 16'h0000, 1'b1, 32'h1000, 16'hA005};
        vecs[1]  = '{1'b0, 12'h00A, 16'h0000, 1'b0, 32'h0,    16'hA00A};
        vecs[2]  = '{1'b1, 12'h003, 16'hBEEF, 1'b0, 32'h1006, 16'h0000};
        vecs[3]  = '{1'b0, 12'h003, 16'h0000, 1'b0, 32'h0,    16'hBEEF};
        vecs[4]  = '{1'b1, 12'h020, 16'h1234, 1'b0, 32'h1040, 16'h0000};
        vecs[5]  = '{1'b0, 12'h00A, 16'h0000, 1'b0, 32'h0,    16'hA00A};
        vecs[6]  = '{1'b0, 12'h00F, 16'h0000, 1'b0, 32'h0,    16'hA00F};
        vecs[7]  = '{1'b0, 12'h000, 16'h0000, 1'b0, 32'h0,    16'hA000};
        vecs[8]  = '{1'b0, 12'h020, 16'h0000, 1'b1, 32'h1040, 16'h1234};
        vecs[9]  = '{1'b0, 12'h02F, 16'h0000, 1'b0, 32'h0,    16'hA02F};
        vecs[10] = '{1'b0, 12'h03F, 16'h0000, 1'b1, 32'h1060, 16'hA03F};
        vecs[11] = '{1'b1, 12'h03F, 16'h0F0F, 1'b0, 32'h107E, 16'h0000};
        vecs[12] = '{1'b0, 12'h03F, 16'h0000, 1'b0, 32'h0,    16'h0F0F};
        vecs[13] = '{1'b0, 12'hFFF, 16'h0000, 1'b1, 32'h2FE0, 16'hAFFF};

        // Reset values, sampled while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_arvalid",   32'(bus.arvalid),   32'd0);
        chk("rst_rready",    32'(bus.rready),    32'd0);
        chk("rst_awvalid",   32'(bus.awvalid),   32'd0);
        chk("rst_wvalid",    32'(bus.wvalid),    32'd0);
        chk("rst_bready",    32'(bus.bready),    32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(state_dbg), 32'(S_IDLE));

        for (int i = 0; i < NV; i++) begin
            ar0 = ar_count;
            aw0 = aw_count;
            send_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
            wait_rsp(rd, err, lat, at);
            chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
            chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_aw_count", i), 32'(aw_count - aw0), 32'd1);
                chk($sformatf("v%0d_ar_count", i), 32'(ar_count - ar0), 32'd0);
                chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].axaddr);
                chk($sformatf("v%0d_awlen", i), 32'(cap_awlen), 32'd0);
                chk($sformatf("v%0d_wdata", i), 32'(cap_wdata), 32'(vecs[i].wdata));
                chk($sformatf("v%0d_wlast", i), 32'(cap_wlast), 32'd1);
            end else if (vecs[i].miss) begin
                chk($sformatf("v%0d_ar_count", i), 32'(ar_count - ar0), 32'd1);
                chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].axaddr);
                chk($sformatf("v%0d_arlen", i), 32'(cap_arlen), 32'd15);
                chk($sformatf("v%0d_arsize", i), 32'(cap_arsize), 32'd1);
                chk($sformatf("v%0d_arburst", i), 32'(cap_arburst), 32'd1);
                chk($sformatf("v%0d_rsp_after_rlast", i), 32'(at), 32'(rlast_cyc));
            end else begin
                chk($sformatf("v%0d_ar_count", i), 32'(ar_count - ar0), 32'd0);
                chk($sformatf("v%0d_hit_latency", i), 32'(lat), 32'd0);
            end
        end

        // Flush together with a request: the request must miss.
        ar0 = ar_count;
        send_req(1'b0, 12'hFF5, 16'h0, 1'b1);
        wait_rsp(rd, err, lat, at);
        chk("flush_req_miss", 32'(ar_count - ar0), 32'd1);
        chk("flush_req_rdata", 32'(rd), 32'hAFF5);

        // Flush alone while idle.
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        ar0 = ar_count;
        send_req(1'b0, 12'hFF6, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        chk("flush_idle_miss", 32'(ar_count - ar0), 32'd1);
        chk("flush_idle_rdata", 32'(rd), 32'hAFF6);

        // Flush during the fill burst: data returned, line invalid afterwards.
        send_req(1'b0, 12'h012, 16'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.rready) found = 1'b1;
            else @(negedge clk);
        end
        chk("flush_rd_seen_rready", 32'(found), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_rsp(rd, err, lat, at);
        chk("flush_rd_rdata", 32'(rd), 32'hA012);
        ar0 = ar_count;
        send_req(1'b0, 12'h013, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        chk("flush_rd_next_miss", 32'(ar_count - ar0), 32'd1);
        chk("flush_rd_next_araddr", cap_araddr, 32'h1020);
        chk("flush_rd_next_rdata", 32'(rd), 32'hA013);

        // Error response on beat 4 of a fill.
        err_beat = 4;
        send_req(1'b0, 12'h045, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        err_beat = -1;
        chk("rresp_err", 32'(err), 32'd1);
        chk("rresp_err_araddr", cap_araddr, 32'h1080);
        ar0 = ar_count;
        send_req(1'b0, 12'h046, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        chk("rresp_next_miss", 32'(ar_count - ar0), 32'd1);
        chk("rresp_next_err", 32'(err), 32'd0);
        chk("rresp_next_rdata", 32'(rd), 32'hA046);
        ar0 = ar_count;
        send_req(1'b0, 12'h047, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        chk("refill_hit", 32'(ar_count - ar0), 32'd0);
        chk("refill_hit_rdata", 32'(rd), 32'hA047);

        // Write with an error response.
        b_err = 1'b1;
        send_req(1'b1, 12'h100, 16'h5555, 1'b0);
        wait_rsp(rd, err, lat, at);
        b_err = 1'b0;
        chk("bresp_err", 32'(err), 32'd1);
        chk("bresp_err_rdata", 32'(rd), 32'd0);

        // Reset during beat 7 of a fill.
        send_req(1'b0, 12'h057, 16'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.rvalid && rd_beat == 7) found = 1'b1;
        end
        chk("rst_mid_seen_beat7", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_mid_rready",  32'(bus.rready),  32'd0);
        chk("rst_mid_busy",    32'(bus.busy),    32'd0);
        chk("rst_mid_state",   32'(state_dbg),   32'(S_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ar0 = ar_count;
        send_req(1'b0, 12'h046, 16'h0, 1'b0);
        wait_rsp(rd, err, lat, at);
        chk("rst_mid_line_invalid", 32'(ar_count - ar0), 32'd1);
        chk("rst_mid_rdata", 32'(rd), 32'hA046);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
